// File: rtl/irq_nest_ctrl.sv
// Nested priority interrupt controller: latches request edges, takes the highest
// pending source above the running level, and keeps a return stack for preemption.
module irq_nest_ctrl #(
  parameter int                NSRC       = 3,
  parameter int                XLEN       = 32,
  parameter logic [XLEN-1:0]   VEC_BASE   = 32'h0000_0100,
  parameter int                VEC_STRIDE = 4,
  localparam int               LW         = $clog2(NSRC + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NSRC-1:0] irq_req,
  input  logic            instr_valid,
  input  logic            uret,
  input  logic [XLEN-1:0] pc_next,
  input  logic            mie_set,
  input  logic            mie_clr,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [NSRC-1:0] pending,
  output logic [LW-1:0]   cur_lvl,
  output logic [LW-1:0]   depth,
  output logic [XLEN-1:0] epc_top,
  output logic            mie
);

  logic [NSRC-1:0] irq_q;
  logic [NSRC-1:0] irq_rise;
  logic [XLEN-1:0] stack_pc  [NSRC];
  logic [LW-1:0]   stack_lvl [NSRC];

  logic [LW-1:0]   cand;
  logic [LW-1:0]   cand_lvl;
  logic [LW-1:0]   top_idx;
  logic [XLEN-1:0] vec_pc;
  logic            stack_busy;
  logic            do_ret;
  logic            do_take;
  logic [NSRC-1:0] take_mask;

  assign irq_rise = irq_req & ~irq_q;

  // Ascending scan so the highest-index pending source ends up as the candidate.
  always_comb begin
    cand = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (pending[i]) cand = LW'(i);
    end
  end

  assign cand_lvl   = cand + LW'(1);
  assign top_idx    = depth - LW'(1);
  assign stack_busy = (depth != '0);
  assign vec_pc     = VEC_BASE + XLEN'(cand) * XLEN'(VEC_STRIDE);
  assign epc_top    = stack_busy ? stack_pc[top_idx] : '0;

  // A return always beats a take; the take is re-evaluated once the level is restored.
  assign do_ret  = instr_valid & uret & stack_busy;
  assign do_take = instr_valid & mie & (|pending) & (cand_lvl > cur_lvl) & ~(uret & stack_busy);

  always_comb begin
    take_mask = '0;
    if (do_take) take_mask[cand] = 1'b1;
  end

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (do_ret) begin
      redirect    = 1'b1;
      redirect_pc = epc_top;
    end else if (do_take) begin
      redirect    = 1'b1;
      redirect_pc = vec_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q   <= '0;
      pending <= '0;
      cur_lvl <= '0;
      depth   <= '0;
      mie     <= 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        stack_pc[i]  <= '0;
        stack_lvl[i] <= '0;
      end
    end else begin
      irq_q   <= irq_req;
      // A fresh edge on the source being taken keeps it pending.
      pending <= (pending & ~take_mask) | irq_rise;

      if (mie_clr)      mie <= 1'b0;
      else if (mie_set) mie <= 1'b1;

      if (do_ret) begin
        cur_lvl <= stack_lvl[top_idx];
        depth   <= depth - LW'(1);
      end else if (do_take) begin
        stack_pc[depth]  <= pc_next;
        stack_lvl[depth] <= cur_lvl;
        cur_lvl          <= cand_lvl;
        depth            <= depth + LW'(1);
      end
    end
  end

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Bench for irq_nest_ctrl: each step queues the expected combinational redirect and
// post-edge state, then pops and compares them against the running DUT.
module tb_irq_nest_ctrl;

  logic        clk;
  logic        rst_n;
  logic [2:0]  irq_req;
  logic        instr_valid;
  logic        uret;
  logic [31:0] pc_next;
  logic        mie_set;
  logic        mie_clr;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  pending;
  logic [1:0]  cur_lvl;
  logic [1:0]  depth;
  logic [31:0] epc_top;
  logic        mie;

  int n_chk;
  int n_fail;

  typedef struct packed {
    logic        rd;
    logic [31:0] rpc;
    logic [2:0]  pend;
    logic [1:0]  lvl;
    logic [1:0]  dep;
    logic [31:0] epc;
    logic        mie;
  } exp_t;

  exp_t sb_q[$];

  irq_nest_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .irq_req     (irq_req),
    .instr_valid (instr_valid),
    .uret        (uret),
    .pc_next     (pc_next),
    .mie_set     (mie_set),
    .mie_clr     (mie_clr),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pending     (pending),
    .cur_lvl     (cur_lvl),
    .depth       (depth),
    .epc_top     (epc_top),
    .mie         (mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven just after a rising edge; redirect is sampled on the falling
  // edge, registered state one time unit after the next rising edge.
  task automatic step(input string name,
                      input logic [2:0] irq, input logic iv, input logic ur,
                      input logic [31:0] pcn, input logic ms, input logic mc,
                      input logic e_rd, input logic [31:0] e_rpc, input logic [2:0] e_pend,
                      input logic [1:0] e_lvl, input logic [1:0] e_dep,
                      input logic [31:0] e_epc, input logic e_mie);
    exp_t e;
    sb_q.push_back('{rd: e_rd, rpc: e_rpc, pend: e_pend, lvl: e_lvl,
                     dep: e_dep, epc: e_epc, mie: e_mie});
    irq_req     = irq;
    instr_valid = iv;
    uret        = ur;
    pc_next     = pcn;
    mie_set     = ms;
    mie_clr     = mc;
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check_eq({name, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_eq({name, ".redirect"}, 32'(redirect), 32'(e.rd));
      check_eq({name, ".redirect_pc"}, redirect_pc, e.rpc);
      @(posedge clk);
      #1;
      check_eq({name, ".pending"}, 32'(pending), 32'(e.pend));
      check_eq({name, ".cur_lvl"}, 32'(cur_lvl), 32'(e.lvl));
      check_eq({name, ".depth"}, 32'(depth), 32'(e.dep));
      check_eq({name, ".epc_top"}, epc_top, e.epc);
      check_eq({name, ".mie"}, 32'(mie), 32'(e.mie));
    end
  endtask

  task automatic check_all_zero(input string name);
    check_eq({name, ".redirect"}, 32'(redirect), 32'd0);
    check_eq({name, ".redirect_pc"}, redirect_pc, 32'd0);
    check_eq({name, ".pending"}, 32'(pending), 32'd0);
    check_eq({name, ".cur_lvl"}, 32'(cur_lvl), 32'd0);
    check_eq({name, ".depth"}, 32'(depth), 32'd0);
    check_eq({name, ".epc_top"}, epc_top, 32'd0);
    check_eq({name, ".mie"}, 32'(mie), 32'd0);
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    irq_req     = '0;
    instr_valid = 1'b0;
    uret        = 1'b0;
    pc_next     = '0;
    mie_set     = 1'b0;
    mie_clr     = 1'b0;
    #2;
    check_all_zero("reset");
    #5 rst_n = 1'b1;
    @(posedge clk);
    #1;
    //      name       irq     iv ur  pc_next   ms mc  rd rpc       pend    lvl dep epc       mie
    step("latch0",   3'b001, 1, 0, 32'h020, 0, 0,  0, 32'h000, 3'b001, 0, 0, 32'h000, 0);
    step("mie_on",   3'b001, 1, 0, 32'h024, 1, 0,  0, 32'h000, 3'b001, 0, 0, 32'h000, 1);
    step("take0",    3'b001, 1, 0, 32'h040, 0, 0,  1, 32'h100, 3'b000, 1, 1, 32'h040, 1);
    step("latch2",   3'b100, 1, 0, 32'h104, 0, 0,  0, 32'h000, 3'b100, 1, 1, 32'h040, 1);
    step("nest2",    3'b100, 1, 0, 32'h10C, 0, 0,  1, 32'h108, 3'b000, 3, 2, 32'h10C, 1);
    step("latch0b",  3'b101, 1, 0, 32'h200, 0, 0,  0, 32'h000, 3'b001, 3, 2, 32'h10C, 1);
    step("blocked",  3'b101, 1, 0, 32'h204, 0, 0,  0, 32'h000, 3'b001, 3, 2, 32'h10C, 1);
    step("uret1",    3'b101, 1, 1, 32'h208, 0, 0,  1, 32'h10C, 3'b001, 1, 1, 32'h040, 1);
    step("uret2",    3'b101, 1, 1, 32'h110, 0, 0,  1, 32'h040, 3'b001, 0, 0, 32'h000, 1);
    step("take0b",   3'b101, 1, 0, 32'h300, 0, 0,  1, 32'h100, 3'b000, 1, 1, 32'h300, 1);
    step("uret3",    3'b101, 1, 1, 32'h104, 0, 0,  1, 32'h300, 3'b000, 0, 0, 32'h000, 1);
    step("idle",     3'b000, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b000, 0, 0, 32'h000, 1);
    step("both_up",  3'b011, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b011, 0, 0, 32'h000, 1);
    step("no_valid", 3'b011, 0, 0, 32'h444, 0, 0,  0, 32'h000, 3'b011, 0, 0, 32'h000, 1);
    step("take1",    3'b011, 1, 0, 32'h500, 0, 0,  1, 32'h104, 3'b001, 2, 1, 32'h500, 1);
    step("blk_lo",   3'b011, 1, 0, 32'h504, 0, 0,  0, 32'h000, 3'b001, 2, 1, 32'h500, 1);
    step("uret4",    3'b011, 1, 1, 32'h108, 0, 0,  1, 32'h500, 3'b001, 0, 0, 32'h000, 1);
    step("take0c",   3'b011, 1, 0, 32'h600, 0, 0,  1, 32'h100, 3'b000, 1, 1, 32'h600, 1);
    step("uret5",    3'b011, 1, 1, 32'h104, 0, 0,  1, 32'h600, 3'b000, 0, 0, 32'h000, 1);
    step("uret_d0",  3'b011, 1, 1, 32'h700, 0, 0,  0, 32'h000, 3'b000, 0, 0, 32'h000, 1);
    step("mie_both", 3'b011, 0, 0, 32'h000, 1, 1,  0, 32'h000, 3'b000, 0, 0, 32'h000, 0);
    step("latch2b",  3'b100, 1, 0, 32'h000, 0, 0,  0, 32'h000, 3'b100, 0, 0, 32'h000, 0);
    step("mie_off",  3'b100, 1, 0, 32'h004, 0, 0,  0, 32'h000, 3'b100, 0, 0, 32'h000, 0);
    step("mie_on2",  3'b100, 1, 0, 32'h008, 1, 0,  0, 32'h000, 3'b100, 0, 0, 32'h000, 1);
    step("take2",    3'b100, 1, 0, 32'h800, 0, 0,  1, 32'h108, 3'b000, 3, 1, 32'h800, 1);
    step("uret6",    3'b100, 1, 1, 32'h10C, 0, 0,  1, 32'h800, 3'b000, 0, 0, 32'h000, 1);
    step("drop",     3'b000, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b000, 0, 0, 32'h000, 1);
    step("latch1",   3'b010, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b010, 0, 0, 32'h000, 1);
    step("drop1",    3'b000, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b010, 0, 0, 32'h000, 1);
    step("set_wins", 3'b010, 1, 0, 32'h900, 0, 0,  1, 32'h104, 3'b010, 2, 1, 32'h900, 1);
    step("latch2c",  3'b110, 0, 0, 32'h000, 0, 0,  0, 32'h000, 3'b110, 2, 1, 32'h900, 1);
    step("nest2b",   3'b110, 1, 0, 32'hA00, 0, 0,  1, 32'h108, 3'b010, 3, 2, 32'hA00, 1);
    // Hold a pending request that would redirect, then reset between clock edges.
    instr_valid = 1'b1;
    uret        = 1'b1;
    @(negedge clk);
    check_eq("pre_rst.redirect", 32'(redirect), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    instr_valid = 1'b0;
    uret        = 1'b0;
    irq_req     = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst.sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
